// File: rtl/flop_share.sv
// Round-robin front end that lets two requesters share one combinational
// 13-bit floating-point adder, with a held response and per-port counters.

// Sign | 5-bit exponent | 7-bit fraction, no hidden bias tricks: exponent 0 is zero.
// Addition is exact in a wide fixed-point field, then truncated; overflow saturates.
module flop (
  input  logic [12:0] one,
  input  logic [12:0] other,
  output logic [12:0] result
);
  logic [39:0] magA, magB, mag, shifted;
  logic        signR;
  logic [5:0]  lead, expR;

  always_comb begin
    magA = (one[11:7] != 5'd0) ? (40'({1'b1, one[6:0]}) << one[11:7]) : 40'd0;
    magB = (other[11:7] != 5'd0) ? (40'({1'b1, other[6:0]}) << other[11:7]) : 40'd0;
    if (one[12] == other[12]) begin
      mag   = magA + magB;
      signR = one[12];
    end else if (magA >= magB) begin
      mag   = magA - magB;
      signR = one[12];
    end else begin
      mag   = magB - magA;
      signR = other[12];
    end
    lead = 6'd0;
    for (int i = 0; i < 40; i++) begin
      if (mag[i]) lead = 6'(i);
    end
    expR    = lead - 6'd7;
    shifted = mag >> expR;
    if (lead < 6'd8) result = 13'h0000;
    else if (lead > 6'd38) result = {signR, 12'hfff};
    else result = {signR, expR[4:0], shifted[6:0]};
  end
endmodule

// state | meaning
// IDLE  | waiting for a request; grants one port combinationally
// EXEC  | operands latched, adder output captured at the end of the cycle
// RESP  | result held until the consumer takes it
module flop_share #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [12:0]      req0_one,
  input  logic [12:0]      req0_other,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [12:0]      req1_one,
  input  logic [12:0]      req1_other,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [12:0]      rsp_result,
  output logic             busy,
  output logic [CNT_W-1:0] done0_cnt,
  output logic [CNT_W-1:0] done1_cnt
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} stateT;

  stateT       state;
  logic [12:0] opOne, opOther, sumResult;
  logic        opId, lastGrant;
  logic        grant0, grant1, canGrant;

  // Port 0 wins unless port 1 is also asking and port 0 was served last.
  assign canGrant   = (state == IDLE) && !reset;
  assign grant0     = canGrant && req0_valid && (!req1_valid || lastGrant);
  assign grant1     = canGrant && req1_valid && !grant0;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);

  flop adder (
    .one    (opOne),
    .other  (opOther),
    .result (sumResult)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      opOne      <= '0;
      opOther    <= '0;
      opId       <= 1'b0;
      lastGrant  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      done0_cnt  <= '0;
      done1_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            opOne   <= grant0 ? req0_one : req1_one;
            opOther <= grant0 ? (req0_other ^ {req0_sub, 12'h000})
                              : (req1_other ^ {req1_sub, 12'h000});
            opId    <= grant1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= sumResult;
          rsp_id     <= opId;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            lastGrant <= opId;
            if (!opId && (done0_cnt != '1)) done0_cnt <= done0_cnt + 1'b1;
            if (opId && (done1_cnt != '1)) done1_cnt <= done1_cnt + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/flop_share.md
# flop_share

Two-port round-robin arbiter and sequencer for the team's combinational 13-bit floating-point adder `flop` (ports `one`, `other`, `result`). Two independent requesters submit operand pairs over valid/ready handshakes. The block grants one at a time, registers the operands, optionally negates the second operand, and captures the adder output into a held response register. It also keeps per-port completion counters, so both consumers can share one adder instance.

## Interface
Parameters:
- CNT_W, 8, width of each per-port completion counter

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle
- req0_one  in  13  port 0 first operand
- req0_other  in  13  port 0 second operand
- req0_sub  in  1  port 0: 1 = subtract (invert bit 12 of req0_other)
- req1_valid / req1_ready / req1_one / req1_other / req1_sub  same as port 0, for port 1
- rsp_valid  out  1  result held and valid
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  port that issued the current result
- rsp_result  out  13  registered adder output
- busy  out  1  state != IDLE
- done0_cnt  out  CNT_W  completed port 0 operations, saturating
- done1_cnt  out  CNT_W  completed port 1 operations, saturating

## Operation
- Operands are opaque 13-bit words; only bit 12 (sign) is touched, and only when sub=1.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid is high, grant one port and assert its reqN_ready combinationally in that cycle.
  - Latch op_one = reqN_one, op_other = reqN_other with bit 12 XOR reqN_sub, and op_id = N.
  - Go to EXEC.
- EXEC: drive `flop` from op_one/op_other, register its result into rsp_result, set rsp_id = op_id, set rsp_valid = 1, go to RESP.
- RESP: hold rsp_result and rsp_id stable. When rsp_ready = 1: clear rsp_valid, increment done{op_id}_cnt, set last_grant = op_id, go to IDLE.
- Arbitration:
  - One valid port: grant it.
  - Both valid: grant the port that is not last_grant.
  - last_grant resets to 1, so port 0 wins the first tie.
- reqN_ready is never asserted outside IDLE, and never for both ports in one cycle.
- Requester contract: reqN_valid must not depend on reqN_ready. Once asserted, valid and operands must stay stable until accepted. A valid held through a non-IDLE period is accepted on the next eligible IDLE cycle.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Reset (synchronous, mid-operation included):
  - State goes to IDLE.
  - rsp_valid=0, rsp_id=0, rsp_result=0, busy=0.
  - done0_cnt=done1_cnt=0, last_grant=1.
  - Any in-flight request is discarded and produces no response.
  - reqN_ready=0 during the reset cycle.
- Accept on cycle T (valid & ready at edge T): EXEC at T+1, rsp_valid=1 from T+2.
- If rsp_ready is high at T+2, the FSM is in IDLE at T+3 and the next accept happens at T+3. Peak throughput is one operation per 3 cycles.
- Back-pressure: rsp_valid, rsp_id and rsp_result hold indefinitely while rsp_ready=0. No new request is accepted meanwhile.
- rsp_ready high while rsp_valid=0 has no effect.
- The counter increment and last_grant update happen on the same edge as the response handshake.
- Counter increment when already at max: the counter holds at max.

## Test plan
- Reset then idle: all outputs 0, busy=0. Assert req0_valid with one=13'h0123, other=13'h0045, sub=0, rsp_ready=1 → req0_ready=1 at T; rsp_valid=1, rsp_id=0 at T+2; rsp_result equals a golden `flop`(13'h0123, 13'h0045); done0_cnt=1.
- Subtract: req1 with other=13'h1234, sub=1 → adder sees other=13'h0234; rsp_id=1; result matches golden `flop`(one, 13'h0234).
- Both ports valid continuously for 6 operations → grant order 0,1,0,1,0,1; done0_cnt=3, done1_cnt=3; never both ready in one cycle.
- rsp_ready held low 10 cycles after rsp_valid → rsp_result and rsp_id stable, req0_ready/req1_ready stay 0, busy=1. Pulse rsp_ready → IDLE next cycle.
- Reset asserted in EXEC → next cycle rsp_valid=0, counters 0, no response ever emitted for that request. After reset a tie grants port 0.
- CNT_W=2: 5 port-0 operations → done0_cnt reads 1,2,3,3,3.
